// File: rtl/alu_result_capture_if.sv
// rtl/alu_result_capture_if.sv - issue/result/drain signal bundle for alu_result_capture
// Purpose: groups the ALU issue watch, ALU result/flags and the record drain port.
// Ports (members):
//   CE, MODE, CMD, INP_VALID       ALU issue being watched
//   RES, ERR, OFLOW, COUT, G, L, E ALU result and flags
//   OUT_VALID/OUT_READY            record drain handshake
//   OUT_RES, OUT_FLAGS, OUT_CMD, OUT_MODE, OUT_TAG  head record fields
// master drives the ALU side and OUT_READY; slave is the capture block.
interface alu_result_capture_if #(
  parameter int WIDTH = 8,
  parameter int C_W   = 4,
  parameter int TAG_W = 4
);
  logic             CE;
  logic             MODE;
  logic [C_W-1:0]   CMD;
  logic [1:0]       INP_VALID;
  logic [WIDTH:0]   RES;
  logic             ERR;
  logic             OFLOW;
  logic             COUT;
  logic             G;
  logic             L;
  logic             E;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH:0]   OUT_RES;
  logic [6:0]       OUT_FLAGS;
  logic [C_W-1:0]   OUT_CMD;
  logic             OUT_MODE;
  logic [TAG_W-1:0] OUT_TAG;

  modport master (
    output CE, MODE, CMD, INP_VALID, RES, ERR, OFLOW, COUT, G, L, E, OUT_READY,
    input  OUT_VALID, OUT_RES, OUT_FLAGS, OUT_CMD, OUT_MODE, OUT_TAG
  );

  modport slave (
    input  CE, MODE, CMD, INP_VALID, RES, ERR, OFLOW, COUT, G, L, E, OUT_READY,
    output OUT_VALID, OUT_RES, OUT_FLAGS, OUT_CMD, OUT_MODE, OUT_TAG
  );
endinterface

// File: rtl/alu_result_capture.sv
// rtl/alu_result_capture.sv - latency-aware ALU result capture into a tagged FWFT FIFO
// Purpose: tracks each ALU issue for its fixed latency, samples RES and flags when
//   it completes, tags records in issue order and queues them for a valid/ready drain.
// Ports:
//   CLK       clock, all logic on posedge
//   RST       synchronous active-high reset
//   bus       alu_result_capture_if.slave (issue watch, ALU result, record drain)
//   COUNT     FIFO occupancy
//   DROP_CNT  records lost to a full FIFO, saturating
//   COLL_CNT  issues discarded on completion collision, saturating
module alu_result_capture #(
  parameter int WIDTH   = 8,
  parameter int C_W     = 4,
  parameter int LAT_STD = 1,
  parameter int LAT_MUL = 2,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  alu_result_capture_if.slave    bus,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic [7:0]             DROP_CNT,
  output logic [7:0]             COLL_CNT
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int STD_IDX = LAT_STD - 1;
  localparam int MUL_IDX = LAT_MUL - 1;

  typedef struct packed {
    logic             v;
    logic             coll;
    logic [C_W-1:0]   cmd;
    logic             mode;
    logic [TAG_W-1:0] tag;
  } pend_t;

  typedef struct packed {
    logic [WIDTH:0]   res;
    logic [6:0]       flags;
    logic [C_W-1:0]   cmd;
    logic             mode;
    logic [TAG_W-1:0] tag;
  } rec_t;

  // Slot k completes k+1 edges from now; slot 0 is captured on the next edge.
  pend_t            pend_q [LAT_MUL];
  pend_t            pend_d [LAT_MUL];
  logic [TAG_W-1:0] tag_q;
  logic             is_mul;
  int               slot;
  logic             tag_inc;
  logic             coll_inc;

  rec_t             mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [7:0]       drop_cnt_q;
  logic [7:0]       coll_cnt_q;
  rec_t             cap_rec;
  rec_t             head;
  logic             push;
  logic             pop;
  logic             full;
  logic             out_valid;
  logic             accept;
  logic             drop;

  always_comb begin
    for (int k = 0; k < LAT_MUL; k++) pend_d[k] = '0;
    for (int k = 0; k < LAT_MUL - 1; k++) pend_d[k] = pend_q[k + 1];
    is_mul   = bus.MODE && ((bus.CMD == C_W'(9)) || (bus.CMD == C_W'(10)));
    slot     = is_mul ? MUL_IDX : STD_IDX;
    tag_inc  = 1'b0;
    coll_inc = 1'b0;
    if (bus.CE) begin
      // Only one completion per edge: an issue landing on an occupied slot is
      // dropped and the older occupant is marked as having shadowed it.
      if (pend_d[slot].v) begin
        pend_d[slot].coll = 1'b1;
        coll_inc          = 1'b1;
      end else begin
        pend_d[slot].v    = 1'b1;
        pend_d[slot].coll = 1'b0;
        pend_d[slot].cmd  = bus.CMD;
        pend_d[slot].mode = bus.MODE;
        pend_d[slot].tag  = tag_q;
        tag_inc           = 1'b1;
      end
    end
  end

  always_comb begin
    cap_rec.res   = bus.RES;
    cap_rec.flags = {pend_q[0].coll, bus.ERR, bus.OFLOW, bus.COUT, bus.G, bus.L, bus.E};
    cap_rec.cmd   = pend_q[0].cmd;
    cap_rec.mode  = pend_q[0].mode;
    cap_rec.tag   = pend_q[0].tag;
  end

  assign push      = pend_q[0].v;
  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = out_valid && bus.OUT_READY;
  // A pop on the same edge frees the slot the full-FIFO push writes into.
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < LAT_MUL; k++) pend_q[k] <= '0;
      tag_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      coll_cnt_q <= '0;
    end else begin
      for (int k = 0; k < LAT_MUL; k++) pend_q[k] <= pend_d[k];
      if (tag_inc) tag_q <= tag_q + TAG_W'(1);
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(accept) - CW'(pop);
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (coll_inc && (coll_cnt_q != 8'hFF)) coll_cnt_q <= coll_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) mem[wr_ptr] <= cap_rec;
  end

  // Storage is not reset, so head fields are masked to read 0 when empty.
  assign head          = out_valid ? mem[rd_ptr] : '0;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_RES   = head.res;
  assign bus.OUT_FLAGS = head.flags;
  assign bus.OUT_CMD   = head.cmd;
  assign bus.OUT_MODE  = head.mode;
  assign bus.OUT_TAG   = head.tag;
  assign COUNT         = count_q;
  assign DROP_CNT      = drop_cnt_q;
  assign COLL_CNT      = coll_cnt_q;

endmodule
